// File: rtl/mmu_pkg.sv
// Shared MMU definitions: page geometry, FSM state encoding and Wishbone
// classic-cycle constants used by the data-side translation bridge.
package mmu_pkg;

    localparam int unsigned PAGE_BITS_DEF = 12;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FWD    = 2'd2,
        ST_MISS   = 2'd3
    } state_t;

    // Width of a VPN or PPN for a given byte-address page size.
    function automatic int unsigned pn_width(input int unsigned page_bits);
        return 32 - page_bits;
    endfunction

endpackage

// File: rtl/tlb_store.sv
// Direct-mapped TLB storage: per-entry valid/tag/PPN flops, a single write
// port with flush, and a combinational lookup.
module tlb_store
    import mmu_pkg::*;
#(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned PAGE_BITS = PAGE_BITS_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  we,
    input  logic [31-PAGE_BITS:0] wr_vpn,
    input  logic [31-PAGE_BITS:0] wr_ppn,
    input  logic                  wr_valid,
    input  logic                  flush,
    input  logic [31-PAGE_BITS:0] lk_vpn,
    output logic                  hit,
    output logic [31-PAGE_BITS:0] lk_ppn
);

    localparam int unsigned PNW  = pn_width(PAGE_BITS);
    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TAGW = PNW - IDXW;

    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q [ENTRIES];
    logic [PNW-1:0]     ppn_q [ENTRIES];

    logic [IDXW-1:0] wr_idx;
    logic [IDXW-1:0] lk_idx;

    assign wr_idx = wr_vpn[IDXW-1:0];
    assign lk_idx = lk_vpn[IDXW-1:0];

    // Flush wins over a coincident write, so that entry also ends invalid.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (we) begin
            tag_q[wr_idx] <= wr_vpn[PNW-1:IDXW];
            ppn_q[wr_idx] <= wr_ppn;
        end
    end

    always_comb begin
        hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_vpn[PNW-1:IDXW]);
        lk_ppn = ppn_q[lk_idx];
    end

endmodule

// File: rtl/dtlb_bridge.sv
// Data-side TLB bridge between the LM32 dbus master and the arbiter: translates
// each request, forwards hits downstream and terminates misses with an error.
module dtlb_bridge
    import mmu_pkg::*;
#(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned PAGE_BITS = PAGE_BITS_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,

    input  logic [29:0]           s_adr,
    input  logic [31:0]           s_dat_w,
    input  logic [3:0]            s_sel,
    input  logic                  s_cyc,
    input  logic                  s_stb,
    input  logic                  s_we,
    input  logic [2:0]            s_cti,
    input  logic [1:0]            s_bte,
    output logic [31:0]           s_dat_r,
    output logic                  s_ack,
    output logic                  s_err,

    output logic [29:0]           m_adr,
    output logic [31:0]           m_dat_w,
    output logic [3:0]            m_sel,
    output logic                  m_cyc,
    output logic                  m_stb,
    output logic                  m_we,
    output logic [2:0]            m_cti,
    output logic [1:0]            m_bte,
    input  logic [31:0]           m_dat_r,
    input  logic                  m_ack,
    input  logic                  m_err,

    input  logic                  enable,
    input  logic                  tlb_we,
    input  logic [31-PAGE_BITS:0] tlb_vpn,
    input  logic [31-PAGE_BITS:0] tlb_ppn,
    input  logic                  tlb_valid,
    input  logic                  flush,
    output logic                  miss,
    output logic [31-PAGE_BITS:0] miss_vpn
);

    localparam int unsigned PNW  = pn_width(PAGE_BITS);
    localparam int unsigned OFFW = PAGE_BITS - 2;

    state_t          state_q;
    logic [29:0]     adr_q;
    logic [31:0]     dat_q;
    logic [3:0]      sel_q;
    logic            we_q;
    logic            en_q;
    logic [PNW-1:0]  miss_vpn_q;

    logic            tlb_hit;
    logic [PNW-1:0]  tlb_ppn_rd;
    logic            fwd;
    logic            in_miss;

    // Every beat is translated on its own, so burst hints are not needed.
    logic            unused_burst;
    assign unused_burst = ^{s_cti, s_bte};

    tlb_store #(
        .ENTRIES   (ENTRIES),
        .PAGE_BITS (PAGE_BITS)
    ) u_tlb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .we        (tlb_we),
        .wr_vpn    (tlb_vpn),
        .wr_ppn    (tlb_ppn),
        .wr_valid  (tlb_valid),
        .flush     (flush),
        .lk_vpn    (adr_q[29:OFFW]),
        .hit       (tlb_hit),
        .lk_ppn    (tlb_ppn_rd)
    );

    // The latched virtual address is overwritten in place with the physical
    // one, so FWD drives the same register in both translated and bypass mode.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            en_q       <= 1'b0;
            miss_vpn_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_cyc && s_stb) begin
                        adr_q   <= s_adr;
                        dat_q   <= s_dat_w;
                        sel_q   <= s_sel;
                        we_q    <= s_we;
                        en_q    <= enable;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!en_q || tlb_hit) begin
                        if (en_q) begin
                            adr_q <= {tlb_ppn_rd, adr_q[OFFW-1:0]};
                        end
                        state_q <= ST_FWD;
                    end else begin
                        miss_vpn_q <= adr_q[29:OFFW];
                        state_q    <= ST_MISS;
                    end
                end
                ST_FWD: begin
                    if (m_ack || m_err) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MISS: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fwd     = (state_q == ST_FWD);
    assign in_miss = (state_q == ST_MISS);

    always_comb begin
        m_cyc   = fwd;
        m_stb   = fwd;
        m_adr   = fwd ? adr_q : '0;
        m_dat_w = fwd ? dat_q : '0;
        m_sel   = fwd ? sel_q : '0;
        m_we    = fwd & we_q;
        m_cti   = CTI_CLASSIC;
        m_bte   = BTE_LINEAR;
    end

    // Upstream responses are masked while reset is held so a pending
    // downstream ack cannot leak through during the reset cycle.
    always_comb begin
        s_ack   = sys_rst_n & fwd & m_ack;
        s_err   = sys_rst_n & ((fwd & m_err) | in_miss);
        s_dat_r = (sys_rst_n && fwd) ? m_dat_r : '0;
        miss    = sys_rst_n & in_miss;
    end

    assign miss_vpn = miss_vpn_q;

endmodule

// File: tb/tb_dtlb_bridge.sv
// Directed self-checking bench for dtlb_bridge with a single-cycle-ack SRAM model.
module tb_dtlb_bridge;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [29:0] s_adr;
    logic [31:0] s_dat_w;
    logic [3:0]  s_sel;
    logic        s_cyc, s_stb, s_we;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [31:0] s_dat_r;
    logic        s_ack, s_err;
    logic [29:0] m_adr;
    logic [31:0] m_dat_w;
    logic [3:0]  m_sel;
    logic        m_cyc, m_stb, m_we;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic [31:0] m_dat_r;
    logic        m_ack, m_err;
    logic        enable, tlb_we, tlb_valid, flush, miss;
    logic [19:0] tlb_vpn, tlb_ppn, miss_vpn;

    // SRAM model controls
    logic sram_ack = 1'b0;
    logic sram_err = 1'b0;
    logic err_mode = 1'b0;
    logic hold     = 1'b0;
    logic ack_force = 1'b0;

    int total = 0;
    int bad   = 0;

    // Per-transaction observations
    int          ack_cyc, err_cyc, err_cnt, miss_cyc, miss_cnt;
    logic        mcyc_seen, cti_nz, obs_mwe;
    logic [29:0] obs_madr;
    logic [31:0] obs_mdatw, obs_datr;
    logic [3:0]  obs_msel;
    logic [19:0] obs_missvpn;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        sram_ack <= m_cyc & m_stb & ~sram_ack & ~sram_err & ~hold & ~err_mode;
        sram_err <= m_cyc & m_stb & ~sram_ack & ~sram_err & ~hold & err_mode;
    end

    assign m_ack   = sram_ack | ack_force;
    assign m_err   = sram_err;
    assign m_dat_r = m_ack ? 32'hDEADBEEF : 32'h0;

    dtlb_bridge #(
        .ENTRIES   (16),
        .PAGE_BITS (12)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .s_adr     (s_adr),
        .s_dat_w   (s_dat_w),
        .s_sel     (s_sel),
        .s_cyc     (s_cyc),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_cti     (s_cti),
        .s_bte     (s_bte),
        .s_dat_r   (s_dat_r),
        .s_ack     (s_ack),
        .s_err     (s_err),
        .m_adr     (m_adr),
        .m_dat_w   (m_dat_w),
        .m_sel     (m_sel),
        .m_cyc     (m_cyc),
        .m_stb     (m_stb),
        .m_we      (m_we),
        .m_cti     (m_cti),
        .m_bte     (m_bte),
        .m_dat_r   (m_dat_r),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .enable    (enable),
        .tlb_we    (tlb_we),
        .tlb_vpn   (tlb_vpn),
        .tlb_ppn   (tlb_ppn),
        .tlb_valid (tlb_valid),
        .flush     (flush),
        .miss      (miss),
        .miss_vpn  (miss_vpn)
    );

    function automatic logic any_out();
        return |{s_dat_r, s_ack, s_err, m_adr, m_dat_w, m_sel, m_cyc, m_stb,
                 m_we, m_cti, m_bte, miss, miss_vpn};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic tlb_write(input logic [19:0] vpn, input logic [19:0] ppn, input logic fl);
        tlb_we = 1'b1; tlb_vpn = vpn; tlb_ppn = ppn; tlb_valid = 1'b1; flush = fl;
        step();
        tlb_we = 1'b0; flush = 1'b0;
    endtask

    // Issue one request at cycle 0 and record what happens over a bounded window.
    task automatic txn(input logic [29:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel);
        ack_cyc = -1; err_cyc = -1; err_cnt = 0; miss_cyc = -1; miss_cnt = 0;
        mcyc_seen = 1'b0; cti_nz = 1'b0; obs_mwe = 1'b0;
        obs_madr = '0; obs_mdatw = '0; obs_datr = '0; obs_msel = '0; obs_missvpn = '0;
        s_adr = adr; s_we = we; s_dat_w = dat; s_sel = sel; s_cyc = 1'b1; s_stb = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (m_cyc) begin
                mcyc_seen = 1'b1; obs_madr = m_adr; obs_mwe = m_we;
                obs_msel = m_sel; obs_mdatw = m_dat_w;
                if (m_cti != 3'b0 || m_bte != 2'b0) cti_nz = 1'b1;
            end
            if (miss) begin
                miss_cnt++;
                if (miss_cyc < 0) miss_cyc = c;
                obs_missvpn = miss_vpn;
            end
            if (s_ack && ack_cyc < 0) begin
                ack_cyc = c; obs_datr = s_dat_r;
            end
            if (s_err) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (s_ack || s_err) begin
                s_cyc = 1'b0; s_stb = 1'b0;
            end
        end
        s_cyc = 1'b0; s_stb = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        s_adr = '0; s_dat_w = '0; s_sel = '0; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        s_cti = 3'b0; s_bte = 2'b0;
        enable = 1'b1; tlb_we = 1'b0; tlb_vpn = '0; tlb_ppn = '0; tlb_valid = 1'b0; flush = 1'b0;

        step(); step();
        chk("reset_outputs_during", {63'b0, any_out()}, 64'd0);
        sys_rst_n = 1'b1;
        step();
        chk("reset_outputs_after", {63'b0, any_out()}, 64'd0);

        // Miss after reset
        txn(30'h1004, 1'b0, 32'h0, 4'hF);
        chk("miss0_err_cyc", err_cyc, 2);
        chk("miss0_err_cnt", err_cnt, 1);
        chk("miss0_miss_cyc", miss_cyc, 2);
        chk("miss0_miss_cnt", miss_cnt, 1);
        chk("miss0_vpn", obs_missvpn, 20'h00004);
        chk("miss0_no_mcyc", mcyc_seen, 0);
        chk("miss0_no_ack", ack_cyc, -1);

        // Hit read
        tlb_write(20'h00004, 20'h00010, 1'b0);
        txn(30'h1004, 1'b0, 32'h0, 4'hF);
        chk("hitrd_madr", obs_madr, 30'h4004);
        chk("hitrd_ack_cyc", ack_cyc, 3);
        chk("hitrd_datr", obs_datr, 32'hDEADBEEF);
        chk("hitrd_no_err", err_cyc, -1);
        chk("hitrd_mwe", obs_mwe, 0);

        // Hit write
        txn(30'h1008, 1'b1, 32'h12345678, 4'b0011);
        chk("hitwr_madr", obs_madr, 30'h4008);
        chk("hitwr_mwe", obs_mwe, 1);
        chk("hitwr_msel", obs_msel, 4'b0011);
        chk("hitwr_mdatw", obs_mdatw, 32'h12345678);
        chk("hitwr_cti_bte", cti_nz, 0);
        chk("hitwr_ack_cyc", ack_cyc, 3);

        // Aliasing: same index, different tag
        txn(30'h5004, 1'b0, 32'h0, 4'hF);
        chk("alias_miss_cnt", miss_cnt, 1);
        chk("alias_vpn", obs_missvpn, 20'h00014);
        chk("alias_no_mcyc", mcyc_seen, 0);
        txn(30'h1004, 1'b0, 32'h0, 4'hF);
        chk("alias_orig_hit_ack", ack_cyc, 3);
        chk("alias_orig_madr", obs_madr, 30'h4004);
        chk("miss_vpn_hold", miss_vpn, 20'h00014);

        // Flush beats a coincident write
        tlb_write(20'h00005, 20'h00020, 1'b1);
        txn(30'h1004, 1'b0, 32'h0, 4'hF);
        chk("flush_vpn4_miss", miss_cnt, 1);
        chk("flush_vpn4_vpn", obs_missvpn, 20'h00004);
        txn(30'h1400, 1'b0, 32'h0, 4'hF);
        chk("flush_vpn5_miss", miss_cnt, 1);
        chk("flush_vpn5_vpn", obs_missvpn, 20'h00005);
        chk("flush_vpn5_no_mcyc", mcyc_seen, 0);

        // Bypass
        enable = 1'b0;
        txn(30'h1004, 1'b0, 32'h0, 4'hF);
        chk("bypass_madr", obs_madr, 30'h1004);
        chk("bypass_ack_cyc", ack_cyc, 3);
        chk("bypass_no_miss", miss_cnt, 0);

        // Downstream error
        err_mode = 1'b1;
        txn(30'h1004, 1'b0, 32'h0, 4'hF);
        chk("merr_err_cyc", err_cyc, 3);
        chk("merr_no_ack", ack_cyc, -1);
        chk("merr_no_miss", miss_cnt, 0);
        err_mode = 1'b0;

        // Reset while forwarding
        hold = 1'b1;
        s_adr = 30'h1004; s_we = 1'b0; s_sel = 4'hF; s_cyc = 1'b1; s_stb = 1'b1;
        step();
        step();
        chk("rstfwd_mcyc_before", m_cyc, 1);
        sys_rst_n = 1'b0; ack_force = 1'b1; s_cyc = 1'b0; s_stb = 1'b0;
        #1;
        chk("rstfwd_no_ack", s_ack, 0);
        step();
        ack_force = 1'b0;
        #1;
        chk("rstfwd_mcyc_after", m_cyc, 0);
        chk("rstfwd_outputs", {63'b0, any_out()}, 64'd0);
        chk("rstfwd_miss_vpn", miss_vpn, 20'h0);
        sys_rst_n = 1'b1; hold = 1'b0; enable = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
